seg_execute_muldiv: RTL and testbench
=====================================

Name: seg_execute_muldiv

Overview:
Iterative multiply/divide unit for the EX stage, beside the main ALU. It executes MULT, MULTU, DIV and DIVU over a fixed number of cycles and writes a HI/LO result pair. It sequences its own shift/add-subtract datapath with a small FSM. It raises o_busy so the hazard unit can stall the pipeline while an operation is in flight.

Parameters:
LEN, 32, operand width; HI and LO are each LEN bits
NB_OP, 2, width of the operation select
NB_CNT, 6, iteration counter width; must satisfy 2^NB_CNT > LEN

Ports:
i_clk  input  1  system clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_start  input  1  request a new operation; sampled only in IDLE
i_op  input  NB_OP  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
i_data_a  input  LEN  rs operand (multiplicand / dividend)
i_data_b  input  LEN  rt operand (multiplier / divisor)
i_flush  input  1  abort the in-flight operation (branch flush / exception)
o_busy  output  1  high whenever state != IDLE
o_done  output  1  one-cycle pulse when HI/LO are updated
o_hi  output  LEN  HI register (product upper half / remainder)
o_lo  output  LEN  LO register (product lower half / quotient)
o_div_by_zero  output  1  pulses with o_done when a DIV/DIVU had b == 0

Behaviour:
- Reset: i_reset=1 asynchronously forces state=IDLE, counter=0, o_hi=0, o_lo=0, o_done=0, o_div_by_zero=0 and clears all internal registers. Reset mid-operation discards the operation.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC on i_start & ~i_flush. At that edge, latch the op, the operand magnitudes (two's-complement absolute value for MULT/DIV, raw for MULTU/DIVU), both sign bits, and div-by-zero = (op is DIV/DIVU) & (b == 0). Set counter=0.
  - CALC: one iteration per cycle, LEN cycles. Go to FIX when counter == LEN-1.
  - FIX -> DONE: apply sign correction and write o_hi/o_lo.
  - DONE -> IDLE unconditionally.
- Latency: with i_start in cycle 0, CALC occupies cycles 1..LEN, FIX occupies cycle LEN+1, and o_done=1 in cycle LEN+2 (cycle 34 for LEN=32). o_hi/o_lo change only at the FIX->DONE edge and hold until the next completion. o_busy is high in cycles 1..LEN+2.
- i_start while busy: ignored, no queueing.
- Multiply iteration (unsigned shift-add on a 2*LEN accumulator {acc_hi, multiplier}):
  - If the LSB is 1, add the multiplicand to acc_hi with a carry-out bit (LEN+1-bit sum).
  - Then shift the whole accumulator, including carry, right by 1.
- Divide iteration (restoring, on {rem, quot}):
  - Shift left by 1.
  - trial = rem - divisor computed at LEN+1 bits.
  - If trial is non-negative: rem = trial and set quot LSB to 1; otherwise restore rem and set quot LSB to 0.
- Sign fix:
  - MULT: negate the 2*LEN product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - MULTU/DIVU: no correction.
- Divide by zero: runs the full latency, skips sign fix, and writes o_lo = all ones, o_hi = the latched i_data_a (raw value). o_div_by_zero=1 in the o_done cycle.
- DIV 0x80000000 / 0xFFFFFFFF: no special case; the result wraps to LO=0x80000000, HI=0.
- i_flush: synchronous. From any state it moves to IDLE next edge, o_done is not asserted, and o_hi/o_lo keep their previous values. If i_flush arrives in the DONE cycle, o_done still pulses because the result was already committed. i_flush with i_start in IDLE: flush wins and the start is dropped.
- o_done and o_div_by_zero are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared include file: op-code localparams (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and FSM state encodings, reused by the control unit and the hazard unit.
- One sub-module is natural: seg_execute_muldiv_step, a combinational single-iteration datapath (add-shift or subtract-restore). Inputs: acc, operand, mode. Output: next acc.
- The FSM, counter, sign handling and HI/LO registers remain in the top module.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at cycle 0 -> o_done at cycle 34, HI=0xFFFFFFFE, LO=0x00000001, o_busy high in cycles 1..34.
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21). Then DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> LO=0xFFFFFFFF, HI=100, o_div_by_zero=1 together with o_done. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0, o_div_by_zero=0.
- Preload HI/LO=0x1234/0x5678, start DIVU 50/7, assert i_flush at cycle 10 -> IDLE at cycle 11, no o_done, HI/LO stay 0x1234/0x5678. A new start at cycle 12 completes normally at cycle 46 with LO=7, HI=1.
- Pulse i_start with new operands at cycle 5 of a running MULTU 6*7 -> ignored; result HI=0, LO=42 at cycle 34. Assert i_reset asynchronously mid-CALC -> outputs 0 immediately, o_busy=0.
- Back-to-back: start again in the cycle after o_done with the same operands -> second o_done exactly 35 cycles after the first, identical results. Random signed/unsigned operand sweep checked against a reference model.

Source files
------------

// File: rtl/seg_execute_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// seg_execute_muldiv_pkg
// Shared definitions for the EX-stage multiply/divide unit: operation codes,
// FSM state encoding and small op-decode helpers. Also imported by the hazard
// unit so both sides agree on what "busy" states mean.
// -----------------------------------------------------------------------------
package seg_execute_muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   // Bit 1 of the op code selects divide, bit 0 selects the unsigned variant.
   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/seg_execute_muldiv_step.sv
// -----------------------------------------------------------------------------
// seg_execute_muldiv_step
// One iteration of the iterative multiply/divide datapath (purely combinational).
//   acc      : {hi, lo} accumulator. Multiply: {partial product, multiplier}.
//              Divide: {remainder, quotient}.
//   operand  : multiplicand (multiply) or divisor (divide), unsigned magnitude
//   mode     : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_next : accumulator after this iteration
// -----------------------------------------------------------------------------
module seg_execute_muldiv_step #(
   parameter int LEN = 32
) (
   input  logic [2*LEN-1:0] acc,
   input  logic [LEN-1:0]   operand,
   input  logic             mode,
   output logic [2*LEN-1:0] acc_next
);

   logic [LEN:0] sum;     // upper half plus multiplicand, keeps the carry-out
   logic [LEN:0] rem_sh;  // remainder after the left shift (can exceed LEN bits)
   logic [LEN:0] trial;   // rem_sh - divisor; MSB set means it went negative

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      acc_next = '0;
      sum      = {1'b0, acc[2*LEN-1:LEN]};
      if (acc[0]) begin
         sum = sum + {1'b0, operand};
      end
      rem_sh = acc[2*LEN-1:LEN-1];
      trial  = rem_sh - {1'b0, operand};

      if (!mode) begin
         // {carry, sum, multiplier} shifted right by one.
         acc_next = {sum, acc[LEN-1:1]};
      end else if (!trial[LEN]) begin
         acc_next = {trial[LEN-1:0], acc[LEN-2:0], 1'b1};
      end else begin
         // Restore: when the subtraction fails rem_sh < divisor, so it fits LEN bits.
         acc_next = {rem_sh[LEN-1:0], acc[LEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/seg_execute_muldiv.sv
// -----------------------------------------------------------------------------
// seg_execute_muldiv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage. Runs LEN shift/add or
// shift/subtract iterations on unsigned magnitudes, then applies sign fix-up
// and writes the HI/LO pair.
//   i_clk, i_reset  : clock, asynchronous active-high reset
//   i_start, i_op   : launch request (honoured only in IDLE) and op select
//   i_data_a/b      : rs / rt operands
//   i_flush         : abort whatever is in flight, HI/LO untouched
//   o_busy          : high while not IDLE (pipeline stall request)
//   o_done          : one-cycle pulse when HI/LO have just been written
//   o_hi, o_lo      : result registers
//   o_div_by_zero   : pulses with o_done for a divide with b == 0
// -----------------------------------------------------------------------------
module seg_execute_muldiv
   import seg_execute_muldiv_pkg::*;
#(
   parameter int LEN    = 32,
   parameter int NB_OP  = 2,
   parameter int NB_CNT = 6
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [NB_OP-1:0] i_op,
   input  logic [LEN-1:0]   i_data_a,
   input  logic [LEN-1:0]   i_data_b,
   input  logic             i_flush,
   output logic             o_busy,
   output logic             o_done,
   output logic [LEN-1:0]   o_hi,
   output logic [LEN-1:0]   o_lo,
   output logic             o_div_by_zero
);

   state_t             state, next_state;
   logic [NB_CNT-1:0]  cnt;
   logic [NB_OP-1:0]   op_q;
   logic [2*LEN-1:0]   acc, acc_next;
   logic [LEN-1:0]     operand;
   logic [LEN-1:0]     a_raw;       // kept for the divide-by-zero HI value
   logic               sign_a, sign_b, dbz_q;
   logic               load, step_en, commit;
   logic               in_signed, in_div;
   logic [LEN-1:0]     a_mag, b_mag;
   logic [2*LEN-1:0]   prod_fix;
   logic [LEN-1:0]     res_hi, res_lo;

   assign in_signed = op_is_signed(i_op);
   assign in_div    = op_is_div(i_op);
   assign a_mag     = (in_signed && i_data_a[LEN-1]) ? -i_data_a : i_data_a;
   assign b_mag     = (in_signed && i_data_b[LEN-1]) ? -i_data_b : i_data_b;
   assign o_busy    = (state != ST_IDLE);

   seg_execute_muldiv_step #(.LEN(LEN)) u_step (
      .acc      (acc),
      .operand  (operand),
      .mode     (op_is_div(op_q)),
      .acc_next (acc_next)
   );

   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop
         // samples pre-edge values regardless of statement order.
         state <= next_state;
      end
   end

   // Next-state and datapath control
   always_comb begin
      next_state = state;
      load       = 1'b0;
      step_en    = 1'b0;
      commit     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               next_state = ST_CALC;
               load       = 1'b1;
            end
         end
         ST_CALC: begin
            step_en = 1'b1;
            if (cnt == NB_CNT'(LEN - 1)) begin
               next_state = ST_FIX;
            end
         end
         ST_FIX: begin
            next_state = ST_DONE;
            commit     = 1'b1;
         end
         ST_DONE: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
      // Flush overrides everything, including a start in IDLE.
      if (i_flush) begin
         next_state = ST_IDLE;
         load       = 1'b0;
         step_en    = 1'b0;
         commit     = 1'b0;
      end
   end

   // Sign correction of the raw unsigned result
   always_comb begin
      prod_fix = (sign_a ^ sign_b) ? -acc : acc;
      res_hi   = prod_fix[2*LEN-1:LEN];
      res_lo   = prod_fix[LEN-1:0];
      if (dbz_q) begin
         res_hi = a_raw;
         res_lo = '1;
      end else if (op_is_div(op_q)) begin
         res_lo = (sign_a ^ sign_b) ? -acc[LEN-1:0] : acc[LEN-1:0];
         res_hi = sign_a ? -acc[2*LEN-1:LEN] : acc[2*LEN-1:LEN];
      end
   end

   // Datapath and result registers
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         // NOTE: every register here is a plain flop (no memory arrays), so all
         // of them are cleared and a reset mid-operation leaves nothing stale.
         cnt           <= '0;
         op_q          <= '0;
         acc           <= '0;
         operand       <= '0;
         a_raw         <= '0;
         sign_a        <= 1'b0;
         sign_b        <= 1'b0;
         dbz_q         <= 1'b0;
         o_hi          <= '0;
         o_lo          <= '0;
         o_done        <= 1'b0;
         o_div_by_zero <= 1'b0;
      end else begin
         o_done        <= commit;
         o_div_by_zero <= commit & dbz_q;
         if (load) begin
            op_q   <= i_op;
            a_raw  <= i_data_a;
            sign_a <= in_signed & i_data_a[LEN-1];
            sign_b <= in_signed & i_data_b[LEN-1];
            dbz_q  <= in_div & (i_data_b == '0);
            cnt    <= '0;
            if (in_div) begin
               acc     <= {{LEN{1'b0}}, a_mag};
               operand <= b_mag;
            end else begin
               acc     <= {{LEN{1'b0}}, b_mag};
               operand <= a_mag;
            end
         end else if (step_en) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
         end
         if (commit) begin
            o_hi <= res_hi;
            o_lo <= res_lo;
         end
      end
   end

endmodule

// File: tb/tb_seg_execute_muldiv.sv
// -----------------------------------------------------------------------------
// tb_seg_execute_muldiv
// Self-checking bench for seg_execute_muldiv. Expected HI/LO/div-by-zero values
// come from a behavioural reference model and travel through a scoreboard
// queue from the point of launch to the o_done pulse.
// -----------------------------------------------------------------------------
module tb_seg_execute_muldiv;
   import seg_execute_muldiv_pkg::*;

   localparam int LEN     = 32;
   localparam int LATENCY = LEN + 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        flush;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done, dbz;
   logic [31:0] hi, lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   exp_t sb[$];
   int   checks    = 0;
   int   passes    = 0;
   int   cyc_count = 0;

   seg_execute_muldiv #(.LEN(LEN), .NB_OP(2), .NB_CNT(6)) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_start       (start),
      .i_op          (op),
      .i_data_a      (a),
      .i_data_b      (b),
      .i_flush       (flush),
      .o_busy        (busy),
      .o_done        (done),
      .o_hi          (hi),
      .o_lo          (lo),
      .o_div_by_zero (dbz)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_count <= cyc_count + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Reference model: wide signed/unsigned arithmetic, truncating division.
   function automatic exp_t model(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v);
      exp_t        r;
      longint      sa, sbv, q, rm;
      logic [63:0] p, qv, rv;
      sa    = longint'($signed(a_v));
      sbv   = longint'($signed(b_v));
      r.dbz = 1'b0;
      r.hi  = '0;
      r.lo  = '0;
      case (op_v)
         OP_MULT: begin
            p = 64'(sa * sbv);
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         OP_MULTU: begin
            p = {32'b0, a_v} * {32'b0, b_v};
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         default: begin
            if (b_v == 32'd0) begin
               r.hi  = a_v;
               r.lo  = 32'hFFFF_FFFF;
               r.dbz = 1'b1;
            end else if (op_v == OP_DIV) begin
               q  = sa / sbv;
               rm = sa % sbv;
               qv = 64'(q);
               rv = 64'(rm);
               r.lo = qv[31:0];
               r.hi = rv[31:0];
            end else begin
               r.lo = a_v / b_v;
               r.hi = a_v % b_v;
            end
         end
      endcase
      return r;
   endfunction

   // Call at a negedge (cycle 0); returns at the cycle-1 sample point.
   task automatic drive_start(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                              input bit push);
      start = 1'b1;
      op    = op_v;
      a     = a_v;
      b     = b_v;
      if (push) sb.push_back(model(op_v, a_v, b_v));
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait for o_done starting at cycle first_cyc; compare against the scoreboard.
   task automatic wait_done(input string name, input int first_cyc, input int max_cyc,
                            input bit check_busy, output int lat);
      int   c;
      int   busy_low;
      exp_t e;
      c        = first_cyc;
      busy_low = 0;
      while (done !== 1'b1 && c < max_cyc) begin
         if (busy !== 1'b1) busy_low++;
         @(negedge clk);
         c++;
      end
      if (busy !== 1'b1) busy_low++;
      lat = c;
      checks++;
      if (done !== 1'b1) begin
         $display("FAIL %s: no o_done by cycle %0d", name, c);
         lat = -1;
         if (sb.size() > 0) e = sb.pop_front();
      end else if (sb.size() == 0) begin
         $display("FAIL %s: o_done with empty scoreboard (hi=%h lo=%h)", name, hi, lo);
      end else begin
         passes++;
         e = sb.pop_front();
         checks++;
         if (hi !== e.hi) $display("FAIL %s hi: got %h expected %h", name, hi, e.hi);
         else passes++;
         checks++;
         if (lo !== e.lo) $display("FAIL %s lo: got %h expected %h", name, lo, e.lo);
         else passes++;
         checks++;
         if (dbz !== e.dbz) $display("FAIL %s div_by_zero: got %b expected %b", name, dbz, e.dbz);
         else passes++;
      end
      if (check_busy) begin
         checks++;
         if (busy_low != 0) $display("FAIL %s busy: low in %0d in-flight cycles, expected 0", name, busy_low);
         else passes++;
      end
   endtask

   // Full launch-to-idle transaction; leaves the bench at an IDLE negedge.
   task automatic run_op(input string name, input logic [1:0] op_v, input logic [31:0] a_v,
                         input logic [31:0] b_v);
      int lat;
      drive_start(op_v, a_v, b_v, 1'b1);
      wait_done(name, 1, 60, 1'b1, lat);
      checks++;
      if (lat != LATENCY) $display("FAIL %s latency: got %0d expected %0d", name, lat, LATENCY);
      else passes++;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL %s after_done: busy=%b done=%b expected 0 0", name, busy, done);
      else passes++;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, dbz, hi, lo} !== '0)
         $display("FAIL reset_state: busy=%b done=%b dbz=%b hi=%h lo=%h expected all 0", busy, done, dbz, hi, lo);
      else passes++;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) $display("FAIL reset_release busy: got %b expected 0", busy);
      else passes++;
   endtask

   task automatic test_multu_max();
      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
   endtask

   task automatic test_signed();
      run_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7);
      run_op("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
   endtask

   task automatic test_div_boundaries();
      run_op("divu_by_zero", OP_DIVU, 32'd100, 32'd0);
      run_op("div_min_by_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("div_by_zero_signed", OP_DIV, 32'hFFFF_FF00, 32'd0);
   endtask

   task automatic test_flush();
      int done_seen;
      int lat;
      run_op("preload", OP_DIVU, 32'h5678_1234, 32'h0001_0000);
      // Start and flush in the same IDLE cycle: the start must be dropped.
      start = 1'b1; flush = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd7;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      checks++;
      if (busy !== 1'b0) $display("FAIL flush_beats_start busy: got %b expected 0", busy);
      else passes++;
      // Launch, then flush in cycle 10.
      drive_start(OP_DIVU, 32'd50, 32'd7, 1'b0);
      done_seen = 0;
      repeat (9) begin
         if (done === 1'b1) done_seen++;
         @(negedge clk);
      end
      if (done === 1'b1) done_seen++;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      if (done === 1'b1) done_seen++;
      checks++;
      if (busy !== 1'b0 || done_seen != 0)
         $display("FAIL flush_idle: busy=%b done_pulses=%0d expected 0 0", busy, done_seen);
      else passes++;
      checks++;
      if (hi !== 32'h0000_1234 || lo !== 32'h0000_5678)
         $display("FAIL flush_hold: hi=%h lo=%h expected 00001234 00005678", hi, lo);
      else passes++;
      @(negedge clk);
      drive_start(OP_DIVU, 32'd50, 32'd7, 1'b1);
      wait_done("after_flush", 1, 60, 1'b1, lat);
      checks++;
      if (lat != LATENCY) $display("FAIL after_flush latency: got %0d expected %0d", lat, LATENCY);
      else passes++;
      @(negedge clk);
   endtask

   task automatic test_start_ignored();
      int lat;
      drive_start(OP_MULTU, 32'd6, 32'd7, 1'b1);
      repeat (4) @(negedge clk);
      start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done("start_ignored", 6, 60, 1'b1, lat);
      checks++;
      if (lat != LATENCY) $display("FAIL start_ignored latency: got %0d expected %0d", lat, LATENCY);
      else passes++;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) $display("FAIL start_ignored requeue: busy=%b expected 0", busy);
      else passes++;
   endtask

   task automatic test_async_reset();
      drive_start(OP_MULTU, 32'd123, 32'd456, 1'b0);
      repeat (8) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, dbz, hi, lo} !== '0)
         $display("FAIL async_reset: busy=%b done=%b dbz=%b hi=%h lo=%h expected all 0", busy, done, dbz, hi, lo);
      else passes++;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL async_reset discard: busy=%b done=%b expected 0 0", busy, done);
      else passes++;
   endtask

   task automatic test_back_to_back();
      int lat;
      int t1, t2;
      drive_start(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      wait_done("b2b_first", 1, 60, 1'b1, lat);
      t1 = cyc_count;
      @(negedge clk);
      drive_start(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      wait_done("b2b_second", 1, 60, 1'b1, lat);
      t2 = cyc_count;
      checks++;
      if (t2 - t1 != LATENCY + 1) $display("FAIL b2b gap: got %0d expected %0d", t2 - t1, LATENCY + 1);
      else passes++;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [1:0]  op_v;
      logic [31:0] a_v, b_v;
      for (int i = 0; i < 24; i++) begin
         op_v = 2'($urandom_range(0, 3));
         a_v  = $urandom;
         b_v  = $urandom;
         if ($urandom_range(0, 7) == 0) b_v = 32'd0;
         else if ($urandom_range(0, 3) == 0) b_v = 32'($urandom_range(1, 15));
         run_op($sformatf("random_%0d", i), op_v, a_v, b_v);
      end
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_signed();
      test_div_boundaries();
      test_flush();
      test_start_ignored();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
